// File: rtl/demux_logic_pkg.sv
// Shared types for the demux logic router: function codes for the bitwise unit.
// Optional parity outputs are enabled with DEMUX_LOGIC_PARITY_EN (see router and slot).
package demux_logic_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_XOR  = 2'b00;
    localparam op_t OP_XNOR = 2'b01;
    localparam op_t OP_AND  = 2'b10;
    localparam op_t OP_OR   = 2'b11;

endpackage

// File: rtl/demux_logic_slot.sv
// One-entry output buffer for a single router channel: fill, drain and hold.
// DEMUX_LOGIC_PARITY_EN adds an even-parity bit registered alongside the data.
module demux_logic_slot
    import demux_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
`ifdef DEMUX_LOGIC_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    // A fill wins over a drain at the same edge, so the slot stays valid with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fill) begin
            out_valid <= 1'b1;
            out_data  <= fill_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEMUX_LOGIC_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (fill) begin
            out_parity <= ^fill_data;
        end
    end
`endif

endmodule

// File: rtl/demux_logic_router.sv
// Bitwise XOR/XNOR/AND/OR unit whose result is routed into one of NUM_CH buffered channels.
// DEMUX_LOGIC_PARITY_EN adds the per-channel out_parity port.
module demux_logic_router
    import demux_logic_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_a,
    input  logic [WIDTH-1:0]        in_b,
    input  op_t                     in_op,
    input  logic [SEL_W-1:0]        in_ch,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic                    drop_err
`ifdef DEMUX_LOGIC_PARITY_EN
    ,
    output logic [NUM_CH-1:0]       out_parity
`endif
);

    logic [WIDTH-1:0] result;
    logic             ch_ok;
    logic             accept;

    always_comb begin
        result = in_a ^ in_b;
        case (in_op)
            OP_XOR:  result = in_a ^ in_b;
            OP_XNOR: result = ~(in_a ^ in_b);
            OP_AND:  result = in_a & in_b;
            OP_OR:   result = in_a | in_b;
            default: result = in_a ^ in_b;
        endcase
    end

    // An unmatched select leaves in_ready high so the transaction is swallowed and flagged.
    always_comb begin
        ch_ok    = 1'b0;
        in_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_ch == SEL_W'(k)) begin
                ch_ok    = 1'b1;
                in_ready = !out_valid[k] || out_ready[k];
            end
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else begin
            drop_err <= accept && !ch_ok;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        logic fill;

        assign fill = accept && (in_ch == SEL_W'(k));

        demux_logic_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .fill      (fill),
            .fill_data (result),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH])
`ifdef DEMUX_LOGIC_PARITY_EN
            ,
            .out_parity(out_parity[k])
`endif
        );
    end

endmodule

// File: tb/tb_demux_logic_router.sv
// Directed bench for demux_logic_router: a 4-channel and a 3-channel instance share clk/rst_n.
// Parity checks are compiled in when DEMUX_LOGIC_PARITY_EN is defined.
module tb_demux_logic_router;
    import demux_logic_pkg::*;

    int total = 0;
    int bad   = 0;

    logic        clk;
    logic        rst_n;

    logic        a_valid;
    logic        a_ready;
    logic [7:0]  a_a;
    logic [7:0]  a_b;
    op_t         a_op;
    logic [1:0]  a_ch;
    logic [3:0]  a_ov;
    logic [3:0]  a_or;
    logic [31:0] a_od;
    logic        a_drop;

    logic        b_valid;
    logic        b_ready;
    logic [7:0]  b_a;
    logic [7:0]  b_b;
    op_t         b_op;
    logic [1:0]  b_ch;
    logic [2:0]  b_ov;
    logic [2:0]  b_or;
    logic [23:0] b_od;
    logic        b_drop;

`ifdef DEMUX_LOGIC_PARITY_EN
    logic [3:0]  a_par;
    logic [2:0]  b_par;
`endif

    demux_logic_router #(.WIDTH(8), .NUM_CH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_valid),
        .in_ready  (a_ready),
        .in_a      (a_a),
        .in_b      (a_b),
        .in_op     (a_op),
        .in_ch     (a_ch),
        .out_valid (a_ov),
        .out_ready (a_or),
        .out_data  (a_od),
        .drop_err  (a_drop)
`ifdef DEMUX_LOGIC_PARITY_EN
        ,
        .out_parity(a_par)
`endif
    );

    demux_logic_router #(.WIDTH(8), .NUM_CH(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_valid),
        .in_ready  (b_ready),
        .in_a      (b_a),
        .in_b      (b_b),
        .in_op     (b_op),
        .in_ch     (b_ch),
        .out_valid (b_ov),
        .out_ready (b_or),
        .out_data  (b_od),
        .drop_err  (b_drop)
`ifdef DEMUX_LOGIC_PARITY_EN
        ,
        .out_parity(b_par)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        rst_n   = 1'b0;
        a_valid = 1'b0; a_a = 8'h00; a_b = 8'h00; a_op = OP_XOR; a_ch = 2'd0; a_or = 4'b0000;
        b_valid = 1'b0; b_a = 8'h00; b_b = 8'h00; b_op = OP_XOR; b_ch = 2'd0; b_or = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (a_ov !== 4'b0000) begin bad++; $display("FAIL reset_out_valid got=%b exp=0000", a_ov); end
        total++; if (a_od !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=00000000", a_od); end
        total++; if (a_drop !== 1'b0) begin bad++; $display("FAIL reset_drop_err got=%b exp=0", a_drop); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", a_ready); end
        total++; if (b_ov !== 3'b000 || b_od !== 24'h0 || b_drop !== 1'b0) begin
            bad++; $display("FAIL reset_dut3 valid=%b data=%h drop=%b exp 000/000000/0", b_ov, b_od, b_drop);
        end
`ifdef DEMUX_LOGIC_PARITY_EN
        total++; if (a_par !== 4'b0000) begin bad++; $display("FAIL reset_parity got=%b exp=0000", a_par); end
`endif
    endtask

    task automatic test_xor_xnor;
        @(negedge clk);
        a_valid = 1'b1; a_a = 8'hA5; a_b = 8'h3C; a_op = OP_XOR; a_ch = 2'd2;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL xor_in_ready got=%b exp=1", a_ready); end
        @(posedge clk); #1;
        total++; if (a_ov !== 4'b0100) begin bad++; $display("FAIL xor_out_valid got=%b exp=0100", a_ov); end
        total++; if (a_od[23:16] !== 8'h99) begin bad++; $display("FAIL xor_ch2_data got=%h exp=99", a_od[23:16]); end
        @(negedge clk);
        a_op = OP_XNOR; a_ch = 2'd1;
        @(posedge clk); #1;
        total++; if (a_ov !== 4'b0110) begin bad++; $display("FAIL xnor_out_valid got=%b exp=0110", a_ov); end
        total++; if (a_od[15:8] !== 8'h66) begin bad++; $display("FAIL xnor_ch1_data got=%h exp=66", a_od[15:8]); end
        total++; if (a_od[23:16] !== 8'h99) begin bad++; $display("FAIL xnor_ch2_hold got=%h exp=99", a_od[23:16]); end
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        a_valid = 1'b1; a_ch = 2'd1; a_op = OP_OR; a_a = 8'hF0; a_b = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL bp_blocked_%0d in_ready got=%b exp=0", i, a_ready); end
            @(posedge clk); #1;
            total++; if (a_ov[1] !== 1'b1 || a_od[15:8] !== 8'h66) begin
                bad++; $display("FAIL bp_hold_%0d valid=%b data=%h exp 1/66", i, a_ov[1], a_od[15:8]);
            end
            @(negedge clk);
        end
        a_ch = 2'd0; a_op = OP_AND; a_a = 8'hA5; a_b = 8'h3C;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL bp_ch0_ready got=%b exp=1", a_ready); end
        @(posedge clk); #1;
        total++; if (a_ov !== 4'b0111) begin bad++; $display("FAIL bp_ch0_valid got=%b exp=0111", a_ov); end
        total++; if (a_od[7:0] !== 8'h24 || a_od[15:8] !== 8'h66) begin
            bad++; $display("FAIL bp_ch0_data ch0=%h ch1=%h exp 24/66", a_od[7:0], a_od[15:8]);
        end
        @(negedge clk);
        a_ch = 2'd1; a_op = OP_OR; a_a = 8'hF0; a_b = 8'h0F; a_or = 4'b0010;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", a_ready); end
        total++; if (a_ov[1] !== 1'b1 || a_od[15:8] !== 8'h66) begin
            bad++; $display("FAIL bp_first_deliver valid=%b data=%h exp 1/66", a_ov[1], a_od[15:8]);
        end
        @(posedge clk); #1;
        total++; if (a_ov[1] !== 1'b1 || a_od[15:8] !== 8'hFF) begin
            bad++; $display("FAIL bp_second_deliver valid=%b data=%h exp 1/ff", a_ov[1], a_od[15:8]);
        end
        @(negedge clk);
        a_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (a_ov !== 4'b0101) begin bad++; $display("FAIL bp_drained_valid got=%b exp=0101", a_ov); end
        total++; if (a_od[15:8] !== 8'hFF || a_od[23:16] !== 8'h99) begin
            bad++; $display("FAIL bp_drained_data ch1=%h ch2=%h exp ff/99", a_od[15:8], a_od[23:16]);
        end
        @(negedge clk);
        a_or = 4'b0000;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        a_or = 4'b1000; a_valid = 1'b1; a_ch = 2'd3; a_op = OP_AND; a_a = 8'hF0; a_b = 8'h3C;
        @(posedge clk); #1;
        total++; if (a_ov[3] !== 1'b1 || a_od[31:24] !== 8'h30) begin
            bad++; $display("FAIL b2b_and valid=%b data=%h exp 1/30", a_ov[3], a_od[31:24]);
        end
        @(negedge clk);
        a_op = OP_OR;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", a_ready); end
        @(posedge clk); #1;
        total++; if (a_ov[3] !== 1'b1 || a_od[31:24] !== 8'hFC) begin
            bad++; $display("FAIL b2b_or valid=%b data=%h exp 1/fc", a_ov[3], a_od[31:24]);
        end
        @(negedge clk);
        a_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (a_ov !== 4'b0101 || a_od[31:24] !== 8'hFC) begin
            bad++; $display("FAIL b2b_drain valid=%b ch3=%h exp 0101/fc", a_ov, a_od[31:24]);
        end
        @(negedge clk);
        a_or = 4'b0000;
    endtask

    task automatic test_out_of_range;
        @(negedge clk);
        b_valid = 1'b1; b_ch = 2'd3; b_op = OP_XOR; b_a = 8'hFF; b_b = 8'h00;
        #1;
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL oor_ready got=%b exp=1", b_ready); end
        @(posedge clk); #1;
        total++; if (b_drop !== 1'b1 || b_ov !== 3'b000) begin
            bad++; $display("FAIL oor_drop drop=%b valid=%b exp 1/000", b_drop, b_ov);
        end
        @(negedge clk);
        b_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (b_drop !== 1'b0 || b_ov !== 3'b000) begin
            bad++; $display("FAIL oor_pulse_end drop=%b valid=%b exp 0/000", b_drop, b_ov);
        end
        @(negedge clk);
        b_valid = 1'b1; b_ch = 2'd2; b_op = OP_XNOR; b_a = 8'h0F; b_b = 8'h0F;
        @(posedge clk); #1;
        total++; if (b_ov !== 3'b100 || b_od[23:16] !== 8'hFF || b_drop !== 1'b0) begin
            bad++; $display("FAIL oor_inrange valid=%b data=%h drop=%b exp 100/ff/0", b_ov, b_od[23:16], b_drop);
        end
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        total++; if (a_ov !== 4'b0101) begin bad++; $display("FAIL rstmid_pre_valid got=%b exp=0101", a_ov); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (a_ov !== 4'b0000) begin bad++; $display("FAIL rstmid_valid got=%b exp=0000", a_ov); end
        total++; if (a_drop !== 1'b0 || a_od !== 32'h0) begin
            bad++; $display("FAIL rstmid_clear drop=%b data=%h exp 0/00000000", a_drop, a_od);
        end
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DEMUX_LOGIC_PARITY_EN
        a_valid = 1'b1; a_ch = 2'd0; a_op = OP_XOR; a_a = 8'h01; a_b = 8'h00;
        @(posedge clk); #1;
        total++; if (a_par !== 4'b0001 || a_od[7:0] !== 8'h01) begin
            bad++; $display("FAIL parity par=%b data=%h exp 0001/01", a_par, a_od[7:0]);
        end
        @(negedge clk);
        a_valid = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_xor_xnor();
        test_backpressure();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
